// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared state encoding and default sizing for the TDM transmitter
package i2s_tx_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int MAX_SLOTS_DEF = 8;
  localparam int OFFSET_W_DEF  = 9;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    WAIT_FS,
    OFFSET,
    SHIFT
  } state_t;

endpackage

// File: rtl/i2s_tx_word_serializer.sv
// rtl/i2s_tx_word_serializer.sv - current-word register, bit counter and registered serial output
module i2s_tx_word_serializer #(
  parameter int DATA_W = 32,
  localparam int BW    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              load,
  input  logic              first,
  input  logic              advance,
  input  logic [DATA_W-1:0] load_data,
  input  logic [BW-1:0]     num_bits,
  input  logic              lsb_first,
  output logic              last_bit,
  output logic              sd
);

  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] word;
  logic [BW-1:0]     cnt;
  logic [BW-1:0]     cnt_inc;
  logic [BW-1:0]     first_idx;
  logic [BW-1:0]     next_idx;

  // cnt is the index of the bit currently on sd, so last_bit is true during the final bit
  assign cnt_inc   = cnt + BW'(1);
  assign first_idx = lsb_first ? '0 : num_bits;
  assign next_idx  = lsb_first ? cnt_inc : num_bits - cnt_inc;
  assign word      = load ? load_data : cur;
  assign last_bit  = (cnt == num_bits);

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      cur <= '0;
      cnt <= '0;
      sd  <= 1'b0;
    end else begin
      if (load) cur <= load_data;
      if (first) begin
        cnt <= '0;
        sd  <= word[first_idx];
      end else if (advance) begin
        cnt <= cnt_inc;
        sd  <= cur[next_idx];
      end else begin
        sd  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_tdm_channel.sv
// rtl/i2s_tx_tdm_channel.sv - TDM/DSP serial transmitter with frame-sync offset and shadow word
// Build option I2S_TX_REPEAT_ON_UNDERRUN_EN: an underrun slot re-sends the last loaded word.
module i2s_tx_tdm_channel
  import i2s_tx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_SLOTS = MAX_SLOTS_DEF,
  parameter int OFFSET_W  = OFFSET_W_DEF
) (
  input  logic                         sck_i,
  input  logic                         rstn_i,
  input  logic                         fs_i,
  output logic                         sd_o,
  input  logic [DATA_W-1:0]            fifo_data_i,
  input  logic                         fifo_data_valid_i,
  output logic                         fifo_data_ready_o,
  output logic                         tx_ready_o,
  output logic                         fifo_err_o,
  output logic                         frame_err_o,
  input  logic                         cfg_en_i,
  input  logic [$clog2(DATA_W)-1:0]    cfg_num_bits_i,
  input  logic [$clog2(MAX_SLOTS)-1:0] cfg_num_slots_i,
  input  logic                         cfg_lsb_first_i,
  input  logic [OFFSET_W-1:0]          cfg_offset_i
);

  localparam int BW = $clog2(DATA_W);
  localparam int SW = $clog2(MAX_SLOTS);

  state_t              state, state_next;
  logic [DATA_W-1:0]   shadow, load_data;
  logic                shadow_valid;
  logic [SW-1:0]       slot;
  logic [OFFSET_W-1:0] off_cnt;
  logic [BW-1:0]       nb_q, num_bits;
  logic [SW-1:0]       ns_q, num_slots;
  logic                lsb_q, lsb_first;
  logic [OFFSET_W-1:0] off_q, offset;
  logic                wait_fs, last_bit, final_slot;
  logic                ld, first, advance, clear, slot_clr, slot_inc, off_start, off_inc, ferr;
  logic                begin_frame, restart, pop, underrun;

  // Live configuration is used on the frame-start edge itself, the captured copy afterwards
  assign wait_fs   = (state == WAIT_FS);
  assign num_bits  = wait_fs ? cfg_num_bits_i  : nb_q;
  assign num_slots = wait_fs ? cfg_num_slots_i : ns_q;
  assign lsb_first = wait_fs ? cfg_lsb_first_i : lsb_q;
  assign offset    = wait_fs ? cfg_offset_i    : off_q;

  assign final_slot        = !(slot < num_slots);
  assign fifo_data_ready_o = rstn_i && (state != IDLE) && cfg_en_i && !shadow_valid;
  assign tx_ready_o        = (state == WAIT_FS) || (state == OFFSET) || (state == SHIFT);
  assign pop               = ld && shadow_valid;
  assign underrun          = ld && !shadow_valid;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [DATA_W-1:0] last_word;
  assign load_data = shadow_valid ? shadow : last_word;
  always_ff @(posedge sck_i) begin
    if (!rstn_i || !cfg_en_i) last_word <= '0;
    else if (pop)             last_word <= shadow;
  end
`else
  assign load_data = shadow_valid ? shadow : '0;
`endif

  always_ff @(posedge sck_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ld          = 1'b0;
    first       = 1'b0;
    advance     = 1'b0;
    clear       = 1'b0;
    slot_clr    = 1'b0;
    slot_inc    = 1'b0;
    off_start   = 1'b0;
    off_inc     = 1'b0;
    ferr        = 1'b0;
    begin_frame = 1'b0;
    restart     = 1'b0;
    if (!cfg_en_i) begin
      state_next = IDLE;
      clear      = 1'b1;
    end else begin
      case (state)
        IDLE:    state_next = PRELOAD;
        PRELOAD: if (shadow_valid) state_next = WAIT_FS;
        WAIT_FS: if (fs_i) begin_frame = 1'b1;
        OFFSET: begin
          if (fs_i) begin
            restart = 1'b1;
          end else if (off_cnt == offset) begin
            first      = 1'b1;
            state_next = SHIFT;
          end else begin
            off_inc = 1'b1;
          end
        end
        SHIFT: begin
          if (fs_i && last_bit && final_slot) begin
            begin_frame = 1'b1;
          end else if (fs_i) begin
            restart = 1'b1;
          end else if (last_bit && !final_slot) begin
            slot_inc = 1'b1;
            ld       = 1'b1;
            first    = 1'b1;
          end else if (last_bit) begin
            state_next = WAIT_FS;
          end else begin
            advance = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
      // A new frame loads the shadow word; a misplaced fs re-sends the current word
      if (begin_frame || restart) begin
        ld       = begin_frame;
        ferr     = restart;
        slot_clr = 1'b1;
        if (offset == '0) begin
          first      = 1'b1;
          state_next = SHIFT;
        end else begin
          off_start  = 1'b1;
          state_next = OFFSET;
        end
      end
    end
  end

  always_ff @(posedge sck_i) begin
    if (!rstn_i) begin
      shadow       <= '0;
      shadow_valid <= 1'b0;
      slot         <= '0;
      off_cnt      <= '0;
      nb_q         <= '0;
      ns_q         <= '0;
      lsb_q        <= 1'b0;
      off_q        <= '0;
      fifo_err_o   <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      fifo_err_o  <= underrun;
      frame_err_o <= ferr;
      if (!cfg_en_i) begin
        shadow_valid <= 1'b0;
      end else if (fifo_data_valid_i && fifo_data_ready_o) begin
        shadow       <= fifo_data_i;
        shadow_valid <= 1'b1;
      end else if (pop) begin
        shadow_valid <= 1'b0;
      end
      if (slot_clr)      slot <= '0;
      else if (slot_inc) slot <= slot + SW'(1);
      if (off_start)    off_cnt <= OFFSET_W'(1);
      else if (off_inc) off_cnt <= off_cnt + OFFSET_W'(1);
      if (wait_fs) begin
        nb_q  <= cfg_num_bits_i;
        ns_q  <= cfg_num_slots_i;
        lsb_q <= cfg_lsb_first_i;
        off_q <= cfg_offset_i;
      end
    end
  end

  i2s_tx_word_serializer #(.DATA_W(DATA_W)) u_serializer (
    .clk      (sck_i),
    .rstn     (rstn_i),
    .clear    (clear),
    .load     (ld),
    .first    (first),
    .advance  (advance),
    .load_data(load_data),
    .num_bits (num_bits),
    .lsb_first(lsb_first),
    .last_bit (last_bit),
    .sd       (sd_o)
  );

endmodule
